vid_out_select: RTL and testbench

//  Parametrised output-path selector for the analog/sync outputs of the card top level.
//  - Chooses one of NUM_SRC video sources (e.g. RGBI DAC, composite, scan-doubled) from raw config switches.
//  - Debounces the switches; changes source only at a frame boundary.
//  - Blanks RGB for BLANK_FRAMES frames after a change, so the monitor never sees a torn or glitched frame.

---
 rtl/vid_out_select.sv | 183 ++++++++++++++++++
 tb/tb_vid_out_select.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vid_out_select.sv
// Output-path selector: debounced source select, frame-aligned switching,
// and RGB blanking for a few frames after each change of source.
module vid_out_select #(
  parameter int          NUM_SRC      = 2,
  parameter int          SEL_W        = 1,
  parameter int          RW           = 6,
  parameter int          GW           = 7,
  parameter int          BW           = 6,
  parameter logic [23:0] DEBOUNCE_MAX = 24'd10,
  parameter logic [23:0] VS_TIMEOUT   = 24'd1000,
  parameter int          BLANK_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic [SEL_W-1:0]      sw,
  input  logic [NUM_SRC*RW-1:0] src_red,
  input  logic [NUM_SRC*GW-1:0] src_green,
  input  logic [NUM_SRC*BW-1:0] src_blue,
  input  logic [NUM_SRC-1:0]    src_hsync,
  input  logic [NUM_SRC-1:0]    src_vsync,
  output logic [RW-1:0]         red,
  output logic [GW-1:0]         green,
  output logic [BW-1:0]         blue,
  output logic                  hsync,
  output logic                  vsync,
  output logic [SEL_W-1:0]      sel_active,
  output logic                  switching
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT_VS, ST_BLANK} state_e;

  localparam logic [SEL_W:0]   NUM_SRC_W = (SEL_W+1)'(NUM_SRC);
  localparam logic [SEL_W-1:0] MAX_SEL   = SEL_W'(NUM_SRC - 1);
  localparam logic [3:0]       BLANK_N   = 4'(BLANK_FRAMES);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sw_meta_q, sw_meta_d;
  logic [SEL_W-1:0] sw_sync_q, sw_sync_d;
  logic [SEL_W-1:0] sw_stable_q, sw_stable_d;
  logic [23:0]      db_cnt_q, db_cnt_d;
  logic [SEL_W-1:0] acc_sel_q, acc_sel_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             vs_prev_q, vs_prev_d;
  logic [23:0]      tmo_q, tmo_d;
  logic [3:0]       frame_q, frame_d;
  logic [RW-1:0]    red_q, red_d;
  logic [GW-1:0]    green_q, green_d;
  logic [BW-1:0]    blue_q, blue_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             cur_vs;
  logic             vs_rise;

  // Synchroniser and debounce; out-of-range selects clamp to the last source.
  always_comb begin
    sw_meta_d   = sw;
    sw_sync_d   = sw_meta_q;
    sw_stable_d = sw_sync_q;
    db_cnt_d    = db_cnt_q;
    acc_sel_d   = acc_sel_q;
    if (sw_sync_q != sw_stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q != DEBOUNCE_MAX) begin
      db_cnt_d = db_cnt_q + 24'd1;
    end else begin
      acc_sel_d = ({1'b0, sw_stable_q} >= NUM_SRC_W) ? MAX_SEL : sw_stable_q;
    end
  end

  always_comb begin
    cur_vs = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (sel_q == SEL_W'(i)) cur_vs = src_vsync[i];
    end
    vs_rise = cur_vs & ~vs_prev_q;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;
    frame_d = frame_q;
    case (state_q)
      ST_RUN: begin
        if (acc_sel_q != sel_q) begin
          state_d = ST_WAIT_VS;
          tmo_d   = '0;
        end
      end
      ST_WAIT_VS: begin
        if (acc_sel_q == sel_q) begin
          state_d = ST_RUN;
        end else if (vs_rise || (tmo_q == VS_TIMEOUT)) begin
          sel_d   = acc_sel_q;
          frame_d = '0;
          state_d = (BLANK_N == 4'd0) ? ST_RUN : ST_BLANK;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      ST_BLANK: begin
        if (acc_sel_q != sel_q) begin
          state_d = ST_WAIT_VS;
          tmo_d   = '0;
        end else if (vs_rise) begin
          frame_d = frame_q + 4'd1;
          if ((frame_q + 4'd1) == BLANK_N) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output mux uses next-cycle select/state so the pixel sampled on the
  // switching edge already comes from (and is blanked for) the new source.
  always_comb begin
    vs_prev_d = (sel_d != sel_q) ? 1'b0 : cur_vs;
    red_d     = '0;
    green_d   = '0;
    blue_d    = '0;
    hsync_d   = 1'b0;
    vsync_d   = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (sel_d == SEL_W'(i)) begin
        red_d   = src_red[i*RW +: RW];
        green_d = src_green[i*GW +: GW];
        blue_d  = src_blue[i*BW +: BW];
        hsync_d = src_hsync[i];
        vsync_d = src_vsync[i];
      end
    end
    if (state_d == ST_BLANK) begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= ST_RUN;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      sw_stable_q <= '0;
      db_cnt_q    <= '0;
      acc_sel_q   <= '0;
      sel_q       <= '0;
      vs_prev_q   <= 1'b0;
      tmo_q       <= '0;
      frame_q     <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      sw_stable_q <= sw_stable_d;
      db_cnt_q    <= db_cnt_d;
      acc_sel_q   <= acc_sel_d;
      sel_q       <= sel_d;
      vs_prev_q   <= vs_prev_d;
      tmo_q       <= tmo_d;
      frame_q     <= frame_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign sel_active = sel_q;
  assign switching  = (state_q != ST_RUN);

endmodule

// File: tb/tb_vid_out_select.sv
// Directed bench for vid_out_select: reset, debounce, frame-aligned switch,
// timeout, cancel/clamp and asynchronous reset during blanking.
module tb_vid_out_select;

  logic        clk = 1'b0;
  logic        reset_l;
  logic [1:0]  sw;
  logic [17:0] src_red;
  logic [20:0] src_green;
  logic [17:0] src_blue;
  logic [2:0]  hs;
  logic [2:0]  vs;
  logic [5:0]  red;
  logic [6:0]  green;
  logic [5:0]  blue;
  logic        hsync;
  logic        vsync;
  logic [1:0]  sel_active;
  logic        switching;

  logic [5:0] r [3];
  logic [6:0] g [3];
  logic [5:0] b [3];

  int total = 0;
  int bad   = 0;
  int n;

  assign src_red   = {r[2], r[1], r[0]};
  assign src_green = {g[2], g[1], g[0]};
  assign src_blue  = {b[2], b[1], b[0]};

  always #5 clk = ~clk;

  vid_out_select #(
    .NUM_SRC     (3),
    .SEL_W       (2),
    .RW          (6),
    .GW          (7),
    .BW          (6),
    .DEBOUNCE_MAX(24'd10),
    .VS_TIMEOUT  (24'd1000),
    .BLANK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .reset_l   (reset_l),
    .sw        (sw),
    .src_red   (src_red),
    .src_green (src_green),
    .src_blue  (src_blue),
    .src_hsync (hs),
    .src_vsync (vs),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .hsync     (hsync),
    .vsync     (vsync),
    .sel_active(sel_active),
    .switching (switching)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset with random sources and sw=1
    reset_l = 1'b0;
    sw      = 2'd1;
    for (int i = 0; i < 3; i++) begin
      r[i] = 6'($urandom);
      g[i] = 7'($urandom);
      b[i] = 6'($urandom);
    end
    hs = 3'($urandom);
    vs = 3'($urandom);
    repeat (3) tick();
    check("rst_red", red, 0);
    check("rst_green", green, 0);
    check("rst_hsync", hsync, 0);
    check("rst_sel", sel_active, 0);
    check("rst_switching", switching, 0);

    r[0] = 6'h11; g[0] = 7'h22; b[0] = 6'h33;
    r[1] = 6'h05; g[1] = 7'h45; b[1] = 6'h2A;
    r[2] = 6'h3F; g[2] = 7'h01; b[2] = 6'h15;
    hs = 3'b001;
    vs = 3'b000;
    sw = 2'd0;
    reset_l = 1'b1;
    tick();
    check("rel_red", red, 6'h11);
    check("rel_green", green, 7'h22);
    check("rel_blue", blue, 6'h33);
    check("rel_hsync", hsync, 1);

    // 2: bouncing switch never accepted, then hold 1
    for (int i = 0; i < 18; i++) begin
      sw = (i % 2 == 0) ? 2'd1 : 2'd0;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("bounce_no_switch", switching, 0);
      end
    end
    sw = 2'd1;
    n = 0;
    while (switching !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    // 2 sync stages + 11 stable cycles + accept + state change
    check("debounce_latency", n, 15);

    // 3: frame-aligned switch 0 -> 1 with two blank frames
    repeat (40) tick();
    check("wait_sel_old", sel_active, 0);
    check("wait_red_old", red, 6'h11);
    check("wait_switching", switching, 1);
    hs = 3'b010;
    vs = 3'b001;
    tick();
    check("sw_edge_sel", sel_active, 1);
    check("sw_edge_switching", switching, 1);
    check("sw_edge_red", red, 0);
    check("sw_edge_hsync_new", hsync, 1);
    check("sw_edge_vsync_new", vsync, 0);
    vs = 3'b000;
    repeat (3) tick();
    vs = 3'b010;
    tick();
    check("blank1_red", red, 0);
    check("blank1_vsync", vsync, 1);
    check("blank1_switching", switching, 1);
    vs = 3'b000;
    repeat (3) tick();
    check("blank_hold_green", green, 0);
    vs = 3'b010;
    tick();
    check("blank2_red", red, 6'h05);
    check("blank2_blue", blue, 6'h2A);
    check("blank2_switching", switching, 0);
    vs = 3'b000;
    tick();

    // 4: timeout switch 1 -> 0 with vsync stuck low
    sw = 2'd0;
    n = 0;
    while (switching !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("tmo_enter_wait", switching, 1);
    n = 0;
    while (sel_active !== 2'd0 && n < 1200) begin
      tick();
      n++;
    end
    check("tmo_latency", n, 1001);
    check("tmo_red_blank", red, 0);
    hs = 3'b001;
    vs = 3'b001;
    tick();
    vs = 3'b000;
    repeat (2) tick();
    vs = 3'b001;
    tick();
    check("tmo_run_red", red, 6'h11);
    check("tmo_run_switching", switching, 0);
    vs = 3'b000;
    tick();

    // 5: cancel then clamp
    sw = 2'd2;
    n = 0;
    while (switching !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("cancel_wait", switching, 1);
    check("cancel_sel_old", sel_active, 0);
    sw = 2'd0;
    n = 0;
    while (switching !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check("cancel_run", switching, 0);
    check("cancel_sel", sel_active, 0);
    check("cancel_red", red, 6'h11);
    sw = 2'd3;
    n = 0;
    while (switching !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("clamp_wait", switching, 1);
    hs = 3'b100;
    vs = 3'b001;
    tick();
    check("clamp_sel", sel_active, 2);
    check("clamp_red", red, 0);
    check("clamp_hsync", hsync, 1);

    // 6: asynchronous reset in the middle of blanking
    #2;
    reset_l = 1'b0;
    #1;
    check("arst_sel", sel_active, 0);
    check("arst_switching", switching, 0);
    check("arst_hsync", hsync, 0);
    check("arst_red", red, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
